// File: rtl/timer_pkg.sv
// Shared definitions for the timer_irq peripheral: register-select codes,
// control-register bit positions and the FSM state encoding.
package timer_pkg;

    // Register select codes for the configuration write port.
    localparam logic [1:0] SEL_RELOAD   = 2'd0;
    localparam logic [1:0] SEL_PRESC_LO = 2'd1;
    localparam logic [1:0] SEL_PRESC_HI = 2'd2;
    localparam logic [1:0] SEL_CTRL     = 2'd3;

    // Control register bit positions.
    localparam int CTRL_EN  = 0;
    localparam int CTRL_PER = 1;

    // Timer state: IDLE holds the counter, RUN counts.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage : timer_pkg

// File: rtl/timer_prescaler.sv
// Prescaler for timer_irq: a PRESC_W-bit cycle counter that emits a one-cycle
// tick whenever the count has reached the programmed compare value.
module timer_prescaler #(
    parameter int PRESC_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               clear,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);

    logic [PRESC_W-1:0] r_pcnt;

    // The >= compare means that lowering presc below the current count
    // produces a tick on the next cycle instead of letting the count wrap.
    assign tick = run && (r_pcnt >= presc);

    // Count while running; restart from zero on a tick or an explicit clear.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values of the others, matching the hardware.
        if (reset) begin
            r_pcnt <= '0;
        end else if (clear) begin
            r_pcnt <= '0;
        end else if (run) begin
            if (tick) begin
                r_pcnt <= '0;
            end else begin
                r_pcnt <= r_pcnt + PRESC_W'(1);
            end
        end
    end

endmodule : timer_prescaler

// File: rtl/timer_irq.sv
// timer_irq: programmable down-counting timer that drives the datapath's
// i_timer interrupt request. Software writes reload, a two-half prescaler and
// a control register (EN, PER). Expiry raises a sticky level request that is
// cleared by irq_ack. One-shot and periodic modes are supported.
//
// Optional build macro TIMER_OVERRUN_EN adds the sticky 'overrun' output,
// set when an expiry hits an un-acknowledged request and cleared by any
// control-register write.
module timer_irq
    import timer_pkg::*;
#(
    parameter int                 DATA_W        = 8,
    parameter int                 PRESC_W       = 16,
    parameter logic [PRESC_W-1:0] DEFAULT_PRESC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we_cfg,
    input  logic [1:0]        cfg_sel,
    input  logic [DATA_W-1:0] wdata,
    input  logic              irq_ack,
    output logic              i_timer,
    output logic [DATA_W-1:0] count,
    output logic              running
`ifdef TIMER_OVERRUN_EN
    ,
    output logic              overrun
`endif
);

    // Configuration registers. The EN bit of the control register is not
    // stored separately: it is exactly the RUN state, so clearing it on a
    // one-shot expiry is the RUN -> IDLE transition itself.
    logic [DATA_W-1:0]  r_reload;
    logic [PRESC_W-1:0] r_presc;
    logic               r_per;

    // Timer state.
    state_t             r_state;
    state_t             w_state_nxt;
    logic [DATA_W-1:0]  r_count;
    logic [DATA_W-1:0]  w_count_nxt;
    logic               r_irq;
    logic               w_irq_nxt;

    // Decoded events.
    logic               w_ctrl_wr;
    logic               w_start;
    logic               w_tick;
    logic               w_expire;
    logic               w_presc_run;

    assign w_ctrl_wr = we_cfg && (cfg_sel == SEL_CTRL);
    assign w_start   = w_ctrl_wr && wdata[CTRL_EN];

    // A control write owns the cycle: the prescaler neither advances nor
    // ticks, so a stop holds pcnt and a tick in that cycle is discarded.
    assign w_presc_run = (r_state == ST_RUN) && !w_ctrl_wr;

    timer_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .run   (w_presc_run),
        .clear (w_start),
        .presc (r_presc),
        .tick  (w_tick)
    );

    // Software-visible configuration registers; reload and prescaler writes
    // only change what the next load or compare uses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_reload <= '0;
            r_presc  <= DEFAULT_PRESC;
            r_per    <= 1'b0;
        end else if (we_cfg) begin
            case (cfg_sel)
                SEL_RELOAD:   r_reload <= wdata;
                SEL_PRESC_LO: r_presc[DATA_W-1:0] <= wdata;
                SEL_PRESC_HI: r_presc[PRESC_W-1:DATA_W] <= wdata[PRESC_W-DATA_W-1:0];
                default:      r_per <= wdata[CTRL_PER];
            endcase
        end
    end

    // Next-state, next-count and expiry decode for the IDLE/RUN machine.
    always_comb begin
        // NOTE: every signal driven here gets a default first so that no
        // path leaves it unassigned, which would otherwise infer a latch.
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_expire    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = ST_RUN;
                    w_count_nxt = r_reload;
                end
            end

            ST_RUN: begin
                if (w_ctrl_wr) begin
                    if (wdata[CTRL_EN]) begin
                        w_count_nxt = r_reload;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_tick) begin
                    if (r_count != '0) begin
                        w_count_nxt = r_count - DATA_W'(1);
                    end else begin
                        w_expire = 1'b1;
                        if (r_per) begin
                            w_count_nxt = r_reload;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Pending request: a new expiry beats an acknowledge in the same cycle.
        w_irq_nxt = w_expire || (r_irq && !irq_ack);
    end

    // State, counter and pending-request registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_irq   <= w_irq_nxt;
        end
    end

`ifdef TIMER_OVERRUN_EN
    logic r_overrun;

    // Flag an expiry that lands on a request software has not yet taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else if (w_ctrl_wr) begin
            r_overrun <= 1'b0;
        end else if (w_expire && r_irq && !irq_ack) begin
            r_overrun <= 1'b1;
        end
    end

    assign overrun = r_overrun;
`endif

    assign i_timer = r_irq;
    assign count   = r_count;
    assign running = (r_state == ST_RUN);

endmodule : timer_irq

// File: tb/tb_timer_irq.sv
// Self-checking bench for timer_irq: a table of directed vectors, hand-written
// multi-cycle sequences, then randomized traffic against a behavioural model.
module tb_timer_irq;

    localparam int DATA_W  = 8;
    localparam int PRESC_W = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              we_cfg;
    logic [1:0]        cfg_sel;
    logic [DATA_W-1:0] wdata;
    logic              irq_ack;
    logic              i_timer;
    logic [DATA_W-1:0] count;
    logic              running;
`ifdef TIMER_OVERRUN_EN
    logic              overrun;
`endif

    timer_irq #(
        .DATA_W        (DATA_W),
        .PRESC_W       (PRESC_W),
        .DEFAULT_PRESC (16'd0)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .we_cfg  (we_cfg),
        .cfg_sel (cfg_sel),
        .wdata   (wdata),
        .irq_ack (irq_ack),
        .i_timer (i_timer),
        .count   (count),
        .running (running)
`ifdef TIMER_OVERRUN_EN
        ,
        .overrun (overrun)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: EN doubles as "running"; all values are plain ints.
    int m_reload, m_presc, m_en, m_per, m_count, m_pcnt, m_irq, m_ovr;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_reload = 0; m_presc = 0; m_en = 0; m_per = 0;
        m_count = 0; m_pcnt = 0; m_irq = 0; m_ovr = 0;
    endtask

    // One clock edge of the timer, from the written rules: a control write
    // takes the cycle, otherwise a running timer counts prescaler cycles and
    // steps the counter on each tick; config writes land after the edge.
    task automatic model_step(input int we, input int sel, input int d, input int ack);
        int expire;
        expire = 0;
        if (we != 0 && sel == 3) begin
            m_ovr = 0;
            m_per = (d >> 1) & 1;
            if ((d & 1) != 0) begin
                m_en = 1; m_count = m_reload; m_pcnt = 0;
            end else begin
                m_en = 0;
            end
        end else if (m_en != 0) begin
            if (m_pcnt >= m_presc) begin
                m_pcnt = 0;
                if (m_count > 0) m_count = m_count - 1;
                else begin
                    expire = 1;
                    if (m_per != 0) m_count = m_reload;
                    else m_en = 0;
                end
            end else begin
                m_pcnt = m_pcnt + 1;
            end
        end
        if (expire != 0 && m_irq != 0 && ack == 0) m_ovr = 1;
        m_irq = (expire != 0 || (m_irq != 0 && ack == 0)) ? 1 : 0;
        if (we != 0 && sel == 0) m_reload = d;
        if (we != 0 && sel == 1) m_presc = (m_presc & 32'hff00) | d;
        if (we != 0 && sel == 2) m_presc = (m_presc & 32'h00ff) | (d << 8);
    endtask

    // Drive one cycle of inputs, clock it, advance the model, sample at +1.
    task automatic cycle(input int we, input int sel, input int d, input int ack);
        we_cfg  = (we != 0);
        cfg_sel = 2'(sel);
        wdata   = 8'(d);
        irq_ack = (ack != 0);
        @(posedge clk);
        model_step(we, sel, d, ack);
        #1;
        we_cfg  = 1'b0;
        irq_ack = 1'b0;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_irq"},   int'(i_timer), m_irq);
        check({tag, "_count"}, int'(count),   m_count);
        check({tag, "_run"},   int'(running), m_en);
`ifdef TIMER_OVERRUN_EN
        check({tag, "_ovr"},   int'(overrun), m_ovr);
`endif
    endtask

    typedef struct {
        int we, sel, d, ack;
        int e_irq, e_count, e_run;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int last_rise, prev_irq, ack_nxt, rnd_sel, rnd_d;

        // Directed table: one-shot reload=3/presc=0, then stop/restart.
        vecs.push_back('{1, 0, 3,  0, 0, 0,  0});
        vecs.push_back('{1, 1, 0,  0, 0, 0,  0});
        vecs.push_back('{1, 2, 0,  0, 0, 0,  0});
        vecs.push_back('{1, 3, 1,  0, 0, 3,  1});  // E0
        vecs.push_back('{0, 0, 0,  0, 0, 2,  1});
        vecs.push_back('{0, 0, 0,  0, 0, 1,  1});
        vecs.push_back('{0, 0, 0,  0, 0, 0,  1});
        vecs.push_back('{0, 0, 0,  0, 1, 0,  0});  // E0+4: expiry, one-shot ends
        vecs.push_back('{0, 0, 0,  0, 1, 0,  0});
        vecs.push_back('{0, 0, 0,  1, 0, 0,  0});  // ack clears
        vecs.push_back('{0, 0, 0,  1, 0, 0,  0});  // ack while idle: no effect
        vecs.push_back('{1, 0, 10, 0, 0, 0,  0});
        vecs.push_back('{1, 3, 1,  0, 0, 10, 1});
        vecs.push_back('{0, 0, 0,  0, 0, 9,  1});
        vecs.push_back('{0, 0, 0,  0, 0, 8,  1});
        vecs.push_back('{0, 0, 0,  0, 0, 7,  1});
        vecs.push_back('{1, 3, 0,  0, 0, 7,  0});  // stop: tick discarded
        vecs.push_back('{0, 0, 0,  0, 0, 7,  0});
        vecs.push_back('{1, 3, 1,  0, 0, 10, 1});  // restart reloads
        vecs.push_back('{1, 3, 0,  0, 0, 10, 0});

        reset = 1'b1; we_cfg = 1'b0; cfg_sel = 2'd0; wdata = '0; irq_ack = 1'b0;
        model_reset();
        #12;
        check("reset_irq",   int'(i_timer), 0);
        check("reset_count", int'(count),   0);
        check("reset_run",   int'(running), 0);
        reset = 1'b0;
        #1;

        foreach (vecs[i]) begin
            cycle(vecs[i].we, vecs[i].sel, vecs[i].d, vecs[i].ack);
            check($sformatf("vec%0d_irq", i),   int'(i_timer), vecs[i].e_irq);
            check($sformatf("vec%0d_count", i), int'(count),   vecs[i].e_count);
            check($sformatf("vec%0d_run", i),   int'(running), vecs[i].e_run);
        end

        // Periodic reload=1, presc=2: expiry every 6 cycles, acked next cycle.
        cycle(1, 0, 1, 0);
        cycle(1, 1, 2, 0);
        cycle(1, 3, 3, 0);
        last_rise = -1; prev_irq = 0; ack_nxt = 0;
        for (int k = 1; k <= 30; k++) begin
            cycle(0, 0, 0, ack_nxt);
            if (ack_nxt != 0) check("per_ack_clear", int'(i_timer), 0);
            if (i_timer && prev_irq == 0) begin
                if (last_rise < 0) check("per_first_rise", k, 6);
                else               check("per_interval", k - last_rise, 6);
                last_rise = k;
            end
            prev_irq = int'(i_timer);
            ack_nxt  = int'(i_timer);
        end
        check("per_last_rise", last_rise, 30);

        // Expiry every cycle with ack every cycle: request never drops.
        cycle(1, 0, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(1, 3, 3, 1);
        check("same_e0_irq", int'(i_timer), 0);
        for (int k = 0; k < 10; k++) begin
            cycle(0, 0, 0, 1);
            check($sformatf("same_irq%0d", k), int'(i_timer), 1);
        end

        // Prescaler lowered from 100 to 5 with pcnt at 50.
        cycle(1, 0, 5, 0);
        cycle(1, 1, 100, 0);
        cycle(1, 3, 1, 1);                          // E0: pcnt=0, count=5
        for (int k = 0; k < 50; k++) cycle(0, 0, 0, 0);
        check("presc_hold_count", int'(count), 5);
        cycle(1, 1, 5, 0);                          // pcnt 50 -> 51
        check("presc_wr_count", int'(count), 5);
        cycle(0, 0, 0, 0);
        check("presc_first_tick", int'(count), 4);
        for (int k = 0; k < 5; k++) cycle(0, 0, 0, 0);
        check("presc_no_early", int'(count), 4);
        cycle(0, 0, 0, 0);
        check("presc_tick2", int'(count), 3);
        for (int k = 0; k < 6; k++) cycle(0, 0, 0, 0);
        check("presc_tick3", int'(count), 2);
        check("presc_irq", int'(i_timer), 0);

`ifdef TIMER_OVERRUN_EN
        // No ack: second expiry finds the request still pending.
        cycle(1, 0, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(1, 3, 3, 1);
        cycle(0, 0, 0, 0);
        check("ovr_first_irq", int'(i_timer), 1);
        check("ovr_first", int'(overrun), 0);
        cycle(0, 0, 0, 0);
        check("ovr_second", int'(overrun), 1);
        cycle(1, 3, 3, 0);
        check("ovr_cleared", int'(overrun), 0);
`endif

        // Asynchronous reset while a request is pending and count is nonzero.
        cycle(1, 0, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(1, 3, 1, 0);
        cycle(0, 0, 0, 0);
        cycle(1, 0, 7, 0);
        cycle(1, 3, 1, 0);
        cycle(0, 0, 0, 0);
        check("arst_pre_irq",   int'(i_timer), 1);
        check("arst_pre_count", int'(count),   6);
        #2;
        reset = 1'b1;
        #1;
        check("arst_irq",   int'(i_timer), 0);
        check("arst_count", int'(count),   0);
        check("arst_run",   int'(running), 0);
        reset = 1'b0;
        model_reset();

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            rnd_sel = int'($urandom_range(0, 3));
            case (rnd_sel)
                0:       rnd_d = int'($urandom_range(0, 12));
                1:       rnd_d = int'($urandom_range(0, 7));
                2:       rnd_d = ($urandom_range(0, 7) == 0) ? 1 : 0;
                default: rnd_d = int'($urandom_range(0, 255));
            endcase
            cycle(($urandom_range(0, 7) == 0) ? 1 : 0, rnd_sel, rnd_d,
                  ($urandom_range(0, 2) == 0) ? 1 : 0);
            check_model($sformatf("rnd%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_timer_irq
